// File: rtl/sum_ip_seq_arb_if.sv
// AXI4-Lite master bundle between the arbiter front end and the sum_ip slave.
// Signal names follow the sum_ip S00_AXI port names.
interface sum_ip_seq_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [2:0]        m_axi_arprot;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_rready,
    input  m_axi_awready, m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_rready,
    output m_axi_awready, m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/sum_ip_seq_arb.sv
// Round-robin two-requester front end driving sum_ip over AXI4-Lite:
// write A, write B, read result, then hand the result back to the owner.
module sum_ip_seq_arb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int OPA_OFFS  = 'h0,
  parameter int OPB_OFFS  = 'h4,
  parameter int RES_OFFS  = 'h8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  sum_ip_seq_arb_if.master    axi
);

  localparam logic [ADDR_W-1:0] OPA_ADDR = ADDR_W'(BASE_ADDR + OPA_OFFS);
  localparam logic [ADDR_W-1:0] OPB_ADDR = ADDR_W'(BASE_ADDR + OPB_OFFS);
  localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(BASE_ADDR + RES_OFFS);

  typedef enum logic [2:0] {
    IDLE, WA_ADDR, WA_RESP, WB_ADDR,
    WB_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  state_t            state, nxt;
  logic              rr, g, sel, take;
  logic              aw_ok, w_ok, b_fire, b_err, r_fire;
  logic [DATA_W-1:0] b_q;

  assign axi.m_axi_awprot = 3'b000;
  assign axi.m_axi_arprot = 3'b000;
  assign axi.m_axi_wstrb  = 4'hF;

  // rr names the requester that wins a tie
  assign sel  = (&req_valid) ? rr : req_valid[1];
  assign take = (state == IDLE) && (|req_valid) && !ARESET;
  assign req_ready = take ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign aw_ok  = !axi.m_axi_awvalid || axi.m_axi_awready;
  assign w_ok   = !axi.m_axi_wvalid || axi.m_axi_wready;
  assign b_fire = axi.m_axi_bvalid && axi.m_axi_bready;
  assign b_err  = axi.m_axi_bresp != 2'b00;
  assign r_fire = axi.m_axi_rvalid && axi.m_axi_rready;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = WA_ADDR;
      WA_ADDR: if (aw_ok && w_ok) nxt = WA_RESP;
      WA_RESP: if (b_fire) nxt = b_err ? RESP : WB_ADDR;
      WB_ADDR: if (aw_ok && w_ok) nxt = WB_RESP;
      WB_RESP: if (b_fire) nxt = b_err ? RESP : RD_ADDR;
      RD_ADDR: if (axi.m_axi_arready) nxt = RD_DATA;
      RD_DATA: if (r_fire) nxt = RESP;
      RESP:    if (rsp_ready[g]) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr                <= 1'b0;
      g                 <= 1'b0;
      b_q               <= '0;
      axi.m_axi_awvalid <= 1'b0;
      axi.m_axi_wvalid  <= 1'b0;
      axi.m_axi_awaddr  <= '0;
      axi.m_axi_wdata   <= '0;
      axi.m_axi_bready  <= 1'b0;
      axi.m_axi_arvalid <= 1'b0;
      axi.m_axi_araddr  <= '0;
      axi.m_axi_rready  <= 1'b0;
      rsp_valid         <= 2'b00;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
    end else begin
      axi.m_axi_bready  <= (nxt == WA_RESP) || (nxt == WB_RESP);
      axi.m_axi_rready  <= (nxt == RD_DATA);
      axi.m_axi_arvalid <= (nxt == RD_ADDR);
      rsp_valid         <= (nxt == RESP) ? {g, ~g} : 2'b00;
      if (axi.m_axi_awvalid && axi.m_axi_awready)
        axi.m_axi_awvalid <= 1'b0;
      if (axi.m_axi_wvalid && axi.m_axi_wready)
        axi.m_axi_wvalid <= 1'b0;
      if (take) begin
        g                 <= sel;
        rr                <= ~sel;
        b_q               <= sel ? req_b[2*DATA_W-1:DATA_W]
                                 : req_b[DATA_W-1:0];
        axi.m_axi_wdata   <= sel ? req_a[2*DATA_W-1:DATA_W]
                                 : req_a[DATA_W-1:0];
        axi.m_axi_awaddr  <= OPA_ADDR;
        axi.m_axi_awvalid <= 1'b1;
        axi.m_axi_wvalid  <= 1'b1;
        rsp_data          <= '0;
      end
      if (state == WA_RESP && b_fire && !b_err) begin
        axi.m_axi_awaddr  <= OPB_ADDR;
        axi.m_axi_wdata   <= b_q;
        axi.m_axi_awvalid <= 1'b1;
        axi.m_axi_wvalid  <= 1'b1;
      end
      // a failed write aborts the sequence with a zero result
      if (b_fire && b_err) begin
        rsp_err  <= 1'b1;
        rsp_data <= '0;
      end
      if (nxt == RD_ADDR && state != RD_ADDR)
        axi.m_axi_araddr <= RES_ADDR;
      if (r_fire) begin
        rsp_data <= axi.m_axi_rdata;
        if (axi.m_axi_rresp != 2'b00) rsp_err <= 1'b1;
      end
      if (state == RESP && rsp_ready[g])
        rsp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_ip_seq_arb.sv
// Bench for sum_ip_seq_arb: requesters, AXI4-Lite slave model,
// round-robin reference model and response scoreboard.
module tb_sum_ip_seq_arb;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*DW-1:0] req_a, req_b;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  sum_ip_seq_arb_if #(.DATA_W(DW), .ADDR_W(AW)) axi();

  sum_ip_seq_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .axi(axi.master)
  );

  typedef struct { logic [31:0] a, b; } op_t;
  typedef struct {
    logic [1:0] own; logic [31:0] data; logic err; int acc; bit lat;
  } rsp_t;
  typedef struct { bit rd; logic [3:0] addr; logic [31:0] data; } xf_t;

  op_t  rq0[$], rq1[$];
  rsp_t sb[$];
  xf_t  xq[$];
  int   checks = 0, errors = 0, cyc = 0;

  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int force_mode = 0;
  bit rnd_dly = 0, rnd_rsp = 0, chk_lat = 0;
  int stall [2] = '{0, 0};

  logic [31:0] cur_a [2], cur_b [2];
  logic [1:0]  f_req, exp_rr;
  bit f_aw, f_w, f_b, f_ar, f_r, b_sched, r_sched, b_resp_err;
  bit outstanding = 0, last = 1;
  int mode = 0;
  bit aw_got, w_got;
  logic [3:0]  aw_a;
  logic [31:0] w_d, sl_a, sl_b;
  bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_fire, rfire;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata, p_data;
  logic [1:0]  p_rvv;
  logic        p_err;
  rsp_t e;
  op_t  drv_op;
  bit   have;
  int   aw_wait, w_wait, ar_wait, r_cnt;
  bit   aw_pend, w_pend, ar_pend, r_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic xfer_chk(bit rd, logic [3:0] addr, logic [31:0] data);
    xf_t x;
    if (xq.size() == 0) begin
      checks++; errors++;
      $display("FAIL extra_xfer got rd=%0d addr=%0h want none", rd, addr);
    end else begin
      x = xq.pop_front();
      chk("axi_xfer", {rd, addr, data}, {x.rd, x.addr, x.data});
    end
  endtask

  task automatic accept(bit gi);
    rsp_t r;
    xf_t  x;
    logic [31:0] a, b;
    a = cur_a[gi];
    b = cur_b[gi];
    outstanding = 1;
    last = gi;
    if (force_mode >= 0) mode = force_mode;
    else mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
    r.own = gi ? 2'b10 : 2'b01;
    r.acc = cyc;
    r.lat = chk_lat;
    r.err = (mode != 0);
    r.data = (mode == 0) ? a + b : (mode == 3) ? 32'h55 : 32'h0;
    sb.push_back(r);
    x.rd = 0; x.addr = 4'h0; x.data = a; xq.push_back(x);
    if (mode != 1) begin
      x.rd = 0; x.addr = 4'h4; x.data = b; xq.push_back(x);
    end
    if (mode == 0 || mode == 3) begin
      x.rd = 1; x.addr = 4'h8; x.data = 0; xq.push_back(x);
    end
  endtask

  // monitor, reference model and scoreboard (samples on falling edge)
  initial begin
    forever begin
      @(negedge clk);
      f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
      b_sched = 0; r_sched = 0; f_req = 2'b00;
      if (rst) begin
        outstanding = 0; last = 1; sb.delete(); xq.delete();
        aw_got = 0; w_got = 0; p_rv = 0; p_fire = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        f_aw = axi.m_axi_awvalid && axi.m_axi_awready;
        f_w  = axi.m_axi_wvalid && axi.m_axi_wready;
        f_b  = axi.m_axi_bvalid && axi.m_axi_bready;
        f_ar = axi.m_axi_arvalid && axi.m_axi_arready;
        f_r  = axi.m_axi_rvalid && axi.m_axi_rready;
        f_req = req_valid & req_ready;
        exp_rr = 2'b00;
        if (!outstanding && req_valid != 2'b00)
          exp_rr = (&req_valid) ? (last ? 2'b01 : 2'b10) : req_valid;
        if (exp_rr != 0 || req_ready != 0)
          chk("req_ready", req_ready, exp_rr);
        if (p_awv && !p_awr)
          chk("aw_hold", {axi.m_axi_awvalid, axi.m_axi_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr)
          chk("w_hold", {axi.m_axi_wvalid, axi.m_axi_wdata}, {1'b1, p_wdata});
        if (p_arv && !p_arr)
          chk("ar_hold", {axi.m_axi_arvalid, axi.m_axi_araddr}, {1'b1, p_araddr});
        if (f_aw) begin aw_got = 1; aw_a = axi.m_axi_awaddr; end
        if (f_w) begin w_got = 1; w_d = axi.m_axi_wdata; end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          xfer_chk(0, aw_a, w_d);
          b_sched = 1;
          b_resp_err = (mode == 1 && aw_a == 4'h0) || (mode == 2 && aw_a == 4'h4);
          if (aw_a == 4'h0) sl_a = w_d;
          else if (aw_a == 4'h4) sl_b = w_d;
        end
        if (f_ar) begin xfer_chk(1, axi.m_axi_araddr, 32'h0); r_sched = 1; end
        if (rsp_valid != 0 && !p_rv) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected got %b want none", rsp_valid);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", rsp_valid, e.own);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            if (e.lat) chk("latency", cyc - e.acc, 7);
          end
        end
        if (p_rv && !p_fire)
          chk("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {p_rvv, p_err, p_data});
        rfire = (rsp_valid & rsp_ready) != 2'b00;
        if (rfire) begin
          chk("xfers_done", xq.size(), 0);
          outstanding = 0;
        end
        if (req_ready != 0 && exp_rr != 0) accept(exp_rr[1]);
        p_awv = axi.m_axi_awvalid; p_awr = axi.m_axi_awready;
        p_awaddr = axi.m_axi_awaddr;
        p_wv = axi.m_axi_wvalid; p_wr = axi.m_axi_wready;
        p_wdata = axi.m_axi_wdata;
        p_arv = axi.m_axi_arvalid; p_arr = axi.m_axi_arready;
        p_araddr = axi.m_axi_araddr;
        p_rv = rsp_valid != 0; p_fire = rfire; p_rvv = rsp_valid;
        p_data = rsp_data; p_err = rsp_err;
      end
    end
  end

  // slave model and requester/response drivers (drive after rising edge)
  initial begin
    axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_arready = 0;
    axi.m_axi_bvalid = 0; axi.m_axi_bresp = 0;
    axi.m_axi_rvalid = 0; axi.m_axi_rresp = 0; axi.m_axi_rdata = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; r_pend = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_arready = 0;
        axi.m_axi_bvalid = 0; axi.m_axi_rvalid = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; r_pend = 0;
      end else begin
        if (f_aw) begin axi.m_axi_awready = 0; aw_pend = 0; end
        else if (axi.m_axi_awvalid) begin
          if (!aw_pend) begin
            aw_pend = 1;
            aw_wait = rnd_dly ? int'($urandom_range(0, 3)) : aw_dly;
          end
          if (aw_wait == 0) axi.m_axi_awready = 1;
          else begin aw_wait--; axi.m_axi_awready = 0; end
        end
        if (f_w) begin axi.m_axi_wready = 0; w_pend = 0; end
        else if (axi.m_axi_wvalid) begin
          if (!w_pend) begin
            w_pend = 1;
            w_wait = rnd_dly ? int'($urandom_range(0, 3)) : w_dly;
          end
          if (w_wait == 0) axi.m_axi_wready = 1;
          else begin w_wait--; axi.m_axi_wready = 0; end
        end
        if (f_ar) begin axi.m_axi_arready = 0; ar_pend = 0; end
        else if (axi.m_axi_arvalid) begin
          if (!ar_pend) begin
            ar_pend = 1;
            ar_wait = rnd_dly ? int'($urandom_range(0, 3)) : ar_dly;
          end
          if (ar_wait == 0) axi.m_axi_arready = 1;
          else begin ar_wait--; axi.m_axi_arready = 0; end
        end
        if (f_b) axi.m_axi_bvalid = 0;
        if (b_sched) begin
          axi.m_axi_bvalid = 1;
          axi.m_axi_bresp = b_resp_err ? 2'b10 : 2'b00;
        end
        if (f_r) axi.m_axi_rvalid = 0;
        if (r_sched) begin
          r_pend = 1;
          r_cnt = rnd_dly ? int'($urandom_range(0, 4)) : r_dly;
        end
        if (r_pend) begin
          if (r_cnt == 0) begin
            r_pend = 0;
            axi.m_axi_rvalid = 1;
            axi.m_axi_rdata = (mode == 3) ? 32'h55 : sl_a + sl_b;
            axi.m_axi_rresp = (mode == 3) ? 2'b10 : 2'b00;
          end else r_cnt--;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (f_req[i]) req_valid[i] = 1'b0;
        have = 0;
        if (!req_valid[i]) begin
          if (i == 0 && rq0.size() != 0) begin drv_op = rq0.pop_front(); have = 1; end
          if (i == 1 && rq1.size() != 0) begin drv_op = rq1.pop_front(); have = 1; end
        end
        if (have) begin
          cur_a[i] = drv_op.a; cur_b[i] = drv_op.b;
          req_a[i*DW +: DW] = drv_op.a;
          req_b[i*DW +: DW] = drv_op.b;
          req_valid[i] = 1'b1;
        end
        if (stall[i] > 0 && rsp_valid[i]) begin
          rsp_ready[i] = 1'b0;
          stall[i]--;
        end else begin
          rsp_ready[i] = rnd_rsp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
  end

  task automatic push(int i, logic [31:0] a, logic [31:0] b);
    op_t o;
    o.a = a; o.b = b;
    if (i == 0) rq0.push_back(o);
    else rq1.push_back(o);
  endtask

  task automatic wait_idle(int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = rq0.size() == 0 && rq1.size() == 0 && req_valid == 2'b00 &&
             !outstanding && sb.size() == 0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout got busy want idle within %0d", budget);
    end
  endtask

  initial begin
    bit found;
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_axi_vr", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
                       axi.m_axi_arvalid, axi.m_axi_rready}, 0);
    chk("rst_axi_ad", {axi.m_axi_awaddr, axi.m_axi_araddr, axi.m_axi_wdata}, 0);
    chk("rst_fixed", {axi.m_axi_wstrb, axi.m_axi_awprot, axi.m_axi_arprot},
        {4'hF, 6'h0});
    @(posedge clk); #2 rst = 0;

    chk_lat = 1;
    push(0, 32'd1, 32'd2);
    wait_idle(200);
    chk_lat = 0;

    @(posedge clk); #2 rst = 1;
    push(0, 32'd5, 32'd6);
    push(0, 32'd10, 32'd20);
    push(1, 32'hFFFF_FFFF, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid_in", req_valid, 2'b11);
    chk("rst_req_ready_held", req_ready, 0);
    @(posedge clk); #2 rst = 0;
    wait_idle(300);

    aw_dly = 3; w_dly = 1; ar_dly = 2; r_dly = 4;
    push(1, $urandom, $urandom);
    push(0, $urandom, $urandom);
    wait_idle(300);
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;

    force_mode = 1; push(0, 32'd3, 32'd4); wait_idle(200);
    force_mode = 3; push(1, 32'd9, 32'd9); wait_idle(200);
    force_mode = 2; push(0, 32'd6, 32'd7); wait_idle(200);
    force_mode = 0;

    stall[0] = 10;
    push(0, 32'd100, 32'd200);
    push(1, 32'd1, 32'd1);
    wait_idle(300);

    aw_dly = 3;
    push(0, 32'd40, 32'd2);
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      found = axi.m_axi_awvalid && axi.m_axi_awaddr == 4'h4;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wb_addr_seen got none want awaddr 4");
    end
    #1 rst = 1;
    #1 chk("midrst_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid,
                             axi.m_axi_arvalid, axi.m_axi_bready,
                             axi.m_axi_rready, rsp_valid, req_ready}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    aw_dly = 0;
    push(0, 32'd7, 32'd8);
    wait_idle(200);

    rnd_dly = 1; rnd_rsp = 1; force_mode = -1;
    for (int n = 0; n < 40; n++) begin
      push(int'($urandom_range(0, 1)), $urandom, $urandom);
      repeat ($urandom_range(0, 15)) @(posedge clk);
    end
    wait_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
